// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf interface.
// Packet layout (MSB..LSB): {valid, dest[addr_w-1:0], payload[payload_sz-1:0]}.
// Width helpers are functions so that parameterised modules can size their
// ports from their own parameters. The default-sized constants and the
// packet typedef describe the 8-leaf, 32-bit-payload configuration.
package bft_pkg;

  function automatic int unsigned addr_width(input int unsigned num_leaves);
    return (num_leaves < 2) ? 1 : $clog2(num_leaves);
  endfunction

  function automatic int unsigned packet_width(input int unsigned num_leaves,
                                               input int unsigned payload_sz);
    return 1 + addr_width(num_leaves) + payload_sz;
  endfunction

  // Field positions for an arbitrary configuration.
  function automatic int unsigned valid_bit(input int unsigned num_leaves,
                                            input int unsigned payload_sz);
    return packet_width(num_leaves, payload_sz) - 1;
  endfunction

  function automatic int unsigned dest_hi(input int unsigned num_leaves,
                                          input int unsigned payload_sz);
    return payload_sz + addr_width(num_leaves) - 1;
  endfunction

  function automatic int unsigned dest_lo(input int unsigned payload_sz);
    return payload_sz;
  endfunction

  // Default configuration constants.
  localparam int unsigned NUM_LEAVES_DEF = 8;
  localparam int unsigned PAYLOAD_SZ_DEF = 32;
  localparam int unsigned ADDR_W         = addr_width(NUM_LEAVES_DEF);
  localparam int unsigned P_SZ           = packet_width(NUM_LEAVES_DEF, PAYLOAD_SZ_DEF);
  localparam int unsigned VALID_BIT      = P_SZ - 1;
  localparam int unsigned DEST_HI        = PAYLOAD_SZ_DEF + ADDR_W - 1;
  localparam int unsigned DEST_LO        = PAYLOAD_SZ_DEF;
  localparam int unsigned PAYLOAD_HI     = PAYLOAD_SZ_DEF - 1;
  localparam int unsigned PAYLOAD_LO     = 0;

  typedef struct packed {
    logic                      valid;
    logic [ADDR_W-1:0]         dest;
    logic [PAYLOAD_SZ_DEF-1:0] payload;
  } bft_pkt_t;

endpackage

// File: rtl/bft_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (FIFO becomes empty)
//   push, din    write request and data (ignored when full)
//   pop          read request (ignored when empty)
//   head         current head entry (valid while !empty)
//   full, empty  status derived from registered pointers
// Pointers carry one extra wrap bit: equal pointers mean empty, equal index
// with differing wrap bits means full.
module bft_sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned aw = (depth < 2) ? 1 : $clog2(depth);

  typedef logic [aw:0] ptr_t;

  logic [width-1:0] mem [depth];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             do_push;
  logic             do_pop;

  if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
    $error("bft_sync_fifo: depth must be a power of two and >= 2");
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[aw-1:0]] <= din;
        wr_ptr              <= wr_ptr + ptr_t'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

endmodule

// File: rtl/bft_leaf_interface.sv
// Leaf-side network interface of the BFT.
// TX: user words (din_*) are queued and injected onto bus_o, one packet per
//     cycle, as {1'b1, dest, payload}; bus_o is all-zero when idle.
// RX: packets arriving on bus_i addressed to this leaf are queued for the
//     user (dout_*); packets for other leaves or arriving while the queue is
//     full are dropped and counted (saturating 16-bit counters).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   din_data/din_dest/din_valid     TX word in
//   din_ready                       TX queue can accept
//   bus_o                           packet to the switch
//   bus_i                           packet from the switch (no backpressure)
//   dout_data/dout_valid/dout_ready RX word out (first-word-fall-through)
//   drop_cnt                        RX packets lost to a full queue
//   misroute_cnt                    valid RX packets for another leaf
module bft_leaf_interface
  import bft_pkg::*;
#(
  parameter int unsigned num_leaves = 8,
  parameter int unsigned payload_sz = 32,
  parameter int unsigned addr       = 0,
  parameter int unsigned p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [payload_sz-1:0]               din_data,
  input  logic [addr_width(num_leaves)-1:0]   din_dest,
  input  logic                                din_valid,
  output logic                                din_ready,
  output logic [p_sz-1:0]                     bus_o,
  input  logic [p_sz-1:0]                     bus_i,
  output logic [payload_sz-1:0]               dout_data,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [15:0]                         drop_cnt,
  output logic [15:0]                         misroute_cnt
);

  localparam int unsigned addr_w = addr_width(num_leaves);
  localparam int unsigned tx_w   = addr_w + payload_sz;
  localparam int unsigned v_bit  = valid_bit(num_leaves, payload_sz);
  localparam int unsigned d_hi   = dest_hi(num_leaves, payload_sz);
  localparam int unsigned d_lo   = dest_lo(payload_sz);

  localparam logic [addr_w-1:0] my_addr = addr_w'(addr);

  if (p_sz != packet_width(num_leaves, payload_sz)) begin : g_bad_p_sz
    $error("bft_leaf_interface: p_sz must equal 1 + addr_w + payload_sz");
  end

  // ---------------- TX path ----------------
  logic            ready_en;
  logic            tx_full;
  logic            tx_empty;
  logic            tx_push;
  logic [tx_w-1:0] tx_head;

  // Held low through reset and released on the first edge afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign din_ready = ready_en && !tx_full;
  assign tx_push   = din_valid && din_ready;

  bft_sync_fifo #(
    .width (tx_w),
    .depth (fifo_depth)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (tx_push),
    .pop   (!tx_empty),
    .din   ({din_dest, din_data}),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Injection register: the head is popped and launched every cycle the
  // queue is non-empty, so the bus never carries a stale valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_o <= '0;
    end else if (!tx_empty) begin
      bus_o <= {1'b1, tx_head};
    end else begin
      bus_o <= '0;
    end
  end

  // ---------------- RX path ----------------
  logic              rx_valid;
  logic [addr_w-1:0] rx_dest;
  logic              rx_hit;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_drop;
  logic              rx_misroute;

  assign rx_valid    = bus_i[v_bit];
  assign rx_dest     = bus_i[d_hi:d_lo];
  assign rx_hit      = rx_valid && (rx_dest == my_addr);
  // Full is the pre-edge status: a same-cycle pop does not make room.
  assign rx_push     = rx_hit && !rx_full;
  assign rx_drop     = rx_hit && rx_full;
  assign rx_misroute = rx_valid && (rx_dest != my_addr);

  bft_sync_fifo #(
    .width (payload_sz),
    .depth (fifo_depth)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (rx_push),
    .pop   (dout_valid && dout_ready),
    .din   (bus_i[payload_sz-1:0]),
    .head  (dout_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign dout_valid = !rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt     <= '0;
      misroute_cnt <= '0;
    end else begin
      if (rx_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (rx_misroute && (misroute_cnt != '1)) begin
        misroute_cnt <= misroute_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bft_leaf_interface.sv
module tb_bft_leaf_interface;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din_data = '0;
  logic [2:0]  din_dest = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [35:0] bus_o;
  logic [35:0] bus_i = '0;
  logic [31:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;

  bft_leaf_interface #(
    .num_leaves (8),
    .payload_sz (32),
    .addr       (0),
    .p_sz       (36),
    .fifo_depth (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din_data     (din_data),
    .din_dest     (din_dest),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .bus_o        (bus_o),
    .bus_i        (bus_i),
    .dout_data    (dout_data),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a TX scoreboard of packets with the cycle each must
  // appear on the bus, an RX queue of expected payloads, and counter values.
  typedef struct {
    logic [35:0] pkt;
    int unsigned emit;
  } tx_ent_t;

  tx_ent_t     txq[$];
  logic [31:0] rxq[$];
  int unsigned cyc = 0;
  int unsigned last_emit = 0;
  bit          ready_flag = 1'b0;
  int unsigned m_drop = 0;
  int unsigned m_mis = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_drop     = 0;
    m_mis      = 0;
    ready_flag = 1'b0;
    last_emit  = cyc;
  endtask

  task automatic reset_checks();
    check("rst_bus_o", 64'(bus_o), 64'd0);
    check("rst_din_ready", 64'(din_ready), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout_data", 64'(dout_data), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_misroute_cnt", 64'(misroute_cnt), 64'd0);
  endtask

  // Applies one clock edge to the model using the pre-edge inputs.
  task automatic model_edge();
    tx_ent_t     e;
    bit          rx_pop;
    bit          rx_full;
    int unsigned earliest;
    cyc++;
    // TX: queue capacity 8, ready only once out of reset; packets leave in
    // order, one per cycle, no earlier than the cycle after acceptance.
    if (din_valid && ready_flag && (txq.size() < 8)) begin
      earliest = cyc + 1;
      e.pkt    = {1'b1, din_dest, din_data};
      e.emit   = (earliest > last_emit + 1) ? earliest : last_emit + 1;
      last_emit = e.emit;
      txq.push_back(e);
    end
    ready_flag = 1'b1;
    // RX: capacity 8 judged before this edge's pop.
    rx_pop  = (rxq.size() != 0) && dout_ready;
    rx_full = (rxq.size() >= 8);
    if (rx_pop) void'(rxq.pop_front());
    if (bus_i[35]) begin
      if (bus_i[34:32] == 3'd0) begin
        if (!rx_full) rxq.push_back(bus_i[31:0]);
        else if (m_drop < 65535) m_drop++;
      end else if (m_mis < 65535) begin
        m_mis++;
      end
    end
  endtask

  task automatic monitor();
    if ((txq.size() != 0) && (txq[0].emit == cyc)) begin
      check("bus_o_pkt", 64'(bus_o), 64'(txq[0].pkt));
      void'(txq.pop_front());
    end else begin
      check("bus_o_idle", 64'(bus_o), 64'd0);
    end
    check("din_ready", 64'(din_ready), 64'(ready_flag && (txq.size() < 8)));
    check("dout_valid", 64'(dout_valid), 64'(rxq.size() != 0));
    if (rxq.size() != 0) check("dout_data", 64'(dout_data), 64'(rxq[0]));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("misroute_cnt", 64'(misroute_cnt), 64'(m_mis));
  endtask

  // Model update on the active edge, comparison on the falling edge; reset
  // (including an asynchronous mid-cycle assertion) clears the model and
  // checks the outputs have already gone to their reset values.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
        #1;
        reset_checks();
      end else begin
        model_edge();
        @(negedge clk or posedge reset);
        if (reset) begin
          model_clear();
          #1;
          reset_checks();
        end else begin
          monitor();
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a word offered: nothing may be accepted or sent.
    din_valid = 1'b1;
    din_data  = 32'hAAAA5555;
    din_dest  = 3'd1;
    repeat (5) tick();
    din_valid = 1'b0;
    reset     = 1'b0;
    repeat (2) tick();

    // Single TX packet.
    din_dest  = 3'd5;
    din_data  = 32'hDEADBEEF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();

    // Bursts of three with gaps, incrementing payloads.
    for (int i = 0; i < 20; i++) begin
      din_valid = 1'b1;
      din_data  = 32'(i);
      din_dest  = 3'(i % 8);
      tick();
      if (i % 3 == 2) begin
        din_valid = 1'b0;
        tick();
      end
    end
    din_valid = 1'b0;
    repeat (3) tick();

    // RX normal: hold, then consume.
    bus_i = {1'b1, 3'd0, 32'h12345678};
    tick();
    bus_i = '0;
    repeat (2) tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    tick();

    // RX overflow: ten packets into an eight-entry queue, then drain.
    for (int i = 1; i <= 10; i++) begin
      bus_i = {1'b1, 3'd0, 32'(i)};
      tick();
    end
    bus_i = '0;
    tick();
    dout_ready = 1'b1;
    repeat (10) tick();
    dout_ready = 1'b0;

    // Misrouted packet.
    bus_i = {1'b1, 3'd3, 32'hCAFEF00D};
    tick();
    bus_i = '0;
    tick();

    // Randomised traffic; slow consumer first to provoke overflow.
    for (int n = 0; n < 400; n++) begin
      din_valid  = 1'($urandom_range(0, 1));
      din_data   = $urandom();
      din_dest   = 3'($urandom_range(0, 7));
      bus_i[35]  = ($urandom_range(0, 3) != 0);
      bus_i[34:32] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      bus_i[31:0]  = $urandom();
      dout_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    bus_i      = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (12) tick();
    dout_ready = 1'b0;

    // Mid-stream reset while TX and RX are active.
    for (int n = 0; n < 4; n++) begin
      din_valid = 1'b1;
      din_data  = 32'hB000_0000 + 32'(n);
      din_dest  = 3'(n + 2);
      bus_i     = {1'b1, 3'd0, 32'hC000_0000 + 32'(n)};
      tick();
    end
    bus_i = '0;
    #2;
    reset = 1'b1;
    repeat (3) tick();
    din_valid = 1'b0;
    reset     = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
